// File: rtl/game_flow_controller.sv
// Top-level game sequencer for the pinball design.
// Walks title -> serve -> play -> level-up / game-over -> title, tracks lives
// and level, selects the screen for the drawing mux, gates ball physics and
// pulses a ball respawn. All dwell times are counted in video frames.
module game_flow_controller #(
    parameter int LIVES           = 3,
    parameter int MAX_LEVEL       = 3,
    parameter int RESPAWN_FRAMES  = 60,
    parameter int LEVELUP_FRAMES  = 120,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int CNT_W           = 8,
    localparam int LIVES_W        = $clog2(LIVES + 1),
    localparam int LEVEL_W        = $clog2(MAX_LEVEL + 1)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               key0IsPressed,
    input  logic               ballLost,
    input  logic               levelCleared,
    output logic [1:0]         screenSel,
    output logic               start,
    output logic               gameActive,
    output logic               ballRespawn,
    output logic               gameWon,
    output logic [LIVES_W-1:0] livesLeft,
    output logic [LEVEL_W-1:0] level
);

    // Game states; encoding kept as plain constants for compatibility with
    // the older start-screen code that decoded the state register directly.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SERVE     = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] LEVEL_UP  = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;

    // Screen codes understood by the drawing mux.
    localparam logic [1:0] SCR_TITLE    = 2'd0;
    localparam logic [1:0] SCR_GAME     = 2'd1;
    localparam logic [1:0] SCR_LEVELUP  = 2'd2;
    localparam logic [1:0] SCR_GAMEOVER = 2'd3;

    // Last frame index of each timed state: exit happens on the frame pulse
    // that finds the counter here, giving a dwell of exactly N frames.
    localparam logic [CNT_W-1:0] RESPAWN_LAST  = CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] LEVELUP_LAST  = CNT_W'(LEVELUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAMEOVER_LAST = CNT_W'(GAMEOVER_FRAMES - 1);

    localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               won_q, won_d;
    logic               respawn_q, respawn_d;
    logic               key_d_q;
    logic               key_rise;
    logic               timed_state;
    logic               frame_last;

    // Start-key rising edge; key_d_q resets high so a key held through reset
    // is not mistaken for a fresh press.
    assign key_rise = key0IsPressed & ~key_d_q;

    // Frame counting only runs in the states that have a fixed dwell time.
    assign timed_state = (state_q == SERVE) || (state_q == LEVEL_UP) ||
                         (state_q == GAME_OVER);

    // Decode whether the counter sits on the last frame of the current state.
    always_comb begin
        frame_last = 1'b0;
        case (state_q)
            SERVE:     frame_last = (frame_cnt_q == RESPAWN_LAST);
            LEVEL_UP:  frame_last = (frame_cnt_q == LEVELUP_LAST);
            GAME_OVER: frame_last = (frame_cnt_q == GAMEOVER_LAST);
            default:   frame_last = 1'b0;
        endcase
    end

    // Next-state, lives, level and win-flag logic.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        won_d   = won_q;
        case (state_q)
            IDLE: begin
                if (key_rise) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (startOfFrame && frame_last) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // A cleared level outranks a lost ball in the same cycle, so
                // the ball that fell as the last target was hit is forgiven.
                if (levelCleared) begin
                    if (level_q == LEVEL_MAX) begin
                        state_d = GAME_OVER;
                        won_d   = 1'b1;
                    end else begin
                        state_d = LEVEL_UP;
                        level_d = level_q + LEVEL_ONE;
                    end
                end else if (ballLost) begin
                    if (lives_q == LIVES_ONE) begin
                        lives_d = '0;
                        state_d = GAME_OVER;
                        won_d   = 1'b0;
                    end else begin
                        lives_d = lives_q - LIVES_ONE;
                        state_d = SERVE;
                    end
                end
            end
            LEVEL_UP: begin
                if (startOfFrame && frame_last) begin
                    state_d = SERVE;
                end
            end
            GAME_OVER: begin
                if (startOfFrame && frame_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The title screen always holds a fresh game, including on the very
        // cycle it is entered, so no stale score is shown there.
        if (state_d == IDLE) begin
            lives_d = LIVES_FULL;
            level_d = LEVEL_ONE;
            won_d   = 1'b0;
        end
    end

    // Frame counter: cleared on every state change, advanced on frame pulses
    // only while in a timed state.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (startOfFrame && timed_state) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
    end

    // Respawn pulse fires on the SERVE -> PLAY transition only.
    assign respawn_d = (state_q == SERVE) && (state_d == PLAY);

    // State and game-progress registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            lives_q     <= LIVES_FULL;
            level_q     <= LEVEL_ONE;
            won_q       <= 1'b0;
            respawn_q   <= 1'b0;
            key_d_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            won_q       <= won_d;
            respawn_q   <= respawn_d;
            key_d_q     <= key0IsPressed;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        screenSel = SCR_TITLE;
        case (state_q)
            IDLE:      screenSel = SCR_TITLE;
            SERVE:     screenSel = SCR_GAME;
            PLAY:      screenSel = SCR_GAME;
            LEVEL_UP:  screenSel = SCR_LEVELUP;
            GAME_OVER: screenSel = SCR_GAMEOVER;
            default:   screenSel = SCR_TITLE;
        endcase
    end

    assign start       = (state_q != IDLE);
    assign gameActive  = (state_q == PLAY);
    assign ballRespawn = respawn_q;
    assign gameWon     = won_q;
    assign livesLeft   = lives_q;
    assign level       = level_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus a random run, all
// checked against a frame-countdown model of the game rules.
module tb_game_flow_controller;

    localparam int LIVES    = 3;
    localparam int MAXLVL   = 2;
    localparam int RESPAWN  = 2;
    localparam int LEVELUP  = 3;
    localparam int GAMEOVER = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       key0IsPressed = 1'b0;
    logic       ballLost = 1'b0;
    logic       levelCleared = 1'b0;
    logic [1:0] screenSel;
    logic       start;
    logic       gameActive;
    logic       ballRespawn;
    logic       gameWon;
    logic [1:0] livesLeft;
    logic [1:0] level;

    int checks = 0;
    int errors = 0;

    game_flow_controller #(
        .LIVES(LIVES), .MAX_LEVEL(MAXLVL), .RESPAWN_FRAMES(RESPAWN),
        .LEVELUP_FRAMES(LEVELUP), .GAMEOVER_FRAMES(GAMEOVER), .CNT_W(8)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .key0IsPressed(key0IsPressed), .ballLost(ballLost),
        .levelCleared(levelCleared), .screenSel(screenSel), .start(start),
        .gameActive(gameActive), .ballRespawn(ballRespawn), .gameWon(gameWon),
        .livesLeft(livesLeft), .level(level)
    );

    always #5 clk = ~clk;

    // Reference model: game mode plus frames remaining in the current screen.
    localparam int M_TITLE = 0, M_SERVE = 1, M_PLAY = 2, M_LVLUP = 3, M_OVER = 4;
    int m_mode, m_left, m_lives, m_level;
    bit m_won, m_resp, m_key_prev;

    task automatic model_reset();
        m_mode = M_TITLE; m_left = 0; m_lives = LIVES; m_level = 1;
        m_won = 0; m_resp = 0; m_key_prev = 1;
    endtask

    task automatic model_clock(input bit sof, input bit key, input bit lost, input bit clr);
        bit rise;
        rise = key && !m_key_prev;
        m_key_prev = key;
        m_resp = 0;
        case (m_mode)
            M_TITLE: if (rise) begin m_mode = M_SERVE; m_left = RESPAWN; end
            M_SERVE: if (sof) begin
                m_left--;
                if (m_left == 0) begin m_mode = M_PLAY; m_resp = 1; end
            end
            M_PLAY: begin
                if (clr) begin
                    if (m_level == MAXLVL) begin m_mode = M_OVER; m_won = 1; m_left = GAMEOVER; end
                    else begin m_level++; m_mode = M_LVLUP; m_left = LEVELUP; end
                end else if (lost) begin
                    m_lives--;
                    if (m_lives == 0) begin m_mode = M_OVER; m_won = 0; m_left = GAMEOVER; end
                    else begin m_mode = M_SERVE; m_left = RESPAWN; end
                end
            end
            M_LVLUP: if (sof) begin
                m_left--;
                if (m_left == 0) begin m_mode = M_SERVE; m_left = RESPAWN; end
            end
            M_OVER: if (sof) begin
                m_left--;
                if (m_left == 0) m_mode = M_TITLE;
            end
            default: m_mode = M_TITLE;
        endcase
        if (m_mode == M_TITLE) begin m_lives = LIVES; m_level = 1; m_won = 0; end
    endtask

    function automatic logic [9:0] exp_bus();
        logic [1:0] sel;
        case (m_mode)
            M_TITLE: sel = 2'd0;
            M_LVLUP: sel = 2'd2;
            M_OVER:  sel = 2'd3;
            default: sel = 2'd1;
        endcase
        return {sel, 1'(m_mode != M_TITLE), 1'(m_mode == M_PLAY), 1'(m_resp), 1'(m_won),
                2'(m_lives), 2'(m_level)};
    endfunction

    function automatic logic [9:0] dut_bus();
        return {screenSel, start, gameActive, ballRespawn, gameWon, livesLeft, level};
    endfunction

    // One clock: inputs applied on the falling edge, outputs settled 1 after rise.
    task automatic step(input bit sof, input bit key, input bit lost, input bit clr);
        @(negedge clk);
        startOfFrame = sof; key0IsPressed = key; ballLost = lost; levelCleared = clr;
        model_clock(sof, key, lost, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic serve_out();
        for (int i = 0; i < RESPAWN; i++) step(1, 0, 0, 0);
    endtask

    task automatic start_game();
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        serve_out();
    endtask

    task automatic test_reset();
        key0IsPressed = 1'b1;
        resetN = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        if (dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL reset_key_held: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
        if (screenSel !== 2'd0 || start !== 1'b0) begin
            errors++; $display("FAIL reset_idle: sel=%0d start=%0b exp sel=0 start=0", screenSel, start);
        end
        checks++;
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        if (screenSel !== 2'd1 || start !== 1'b1 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL key_start: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
    endtask

    task automatic test_serve_timing();
        step(1, 1, 0, 0);
        if (gameActive !== 1'b0 || screenSel !== 2'd1 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL serve_frame1: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        if (ballRespawn !== 1'b1 || gameActive !== 1'b1 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL serve_to_play: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
        step(0, 1, 0, 0);
        if (ballRespawn !== 1'b0 || gameActive !== 1'b1) begin
            errors++; $display("FAIL respawn_width: respawn=%0b active=%0b exp 0 1", ballRespawn, gameActive);
        end
        checks++;
    endtask

    task automatic test_lives();
        for (int n = 1; n <= LIVES; n++) begin
            step(0, 0, 1, 0);
            if (livesLeft !== 2'(LIVES - n) || dut_bus() !== exp_bus()) begin
                errors++; $display("FAIL lives_%0d: got %h exp %h", n, dut_bus(), exp_bus());
            end
            checks++;
            if (n < LIVES) begin
                step(1, 0, 1, 0);
                if (livesLeft !== 2'(LIVES - n)) begin
                    errors++; $display("FAIL lost_in_serve: lives=%0d exp %0d", livesLeft, LIVES - n);
                end
                checks++;
                step(1, 0, 0, 0);
            end
        end
        if (screenSel !== 2'd3 || gameWon !== 1'b0) begin
            errors++; $display("FAIL game_over_lost: sel=%0d won=%0b exp 3 0", screenSel, gameWon);
        end
        checks++;
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        if (screenSel !== 2'd3 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL key_in_gameover: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
        for (int i = 0; i < GAMEOVER - 1; i++) step(1, 1, 0, 0);
        if (screenSel !== 2'd3) begin
            errors++; $display("FAIL gameover_dwell: sel=%0d exp 3", screenSel);
        end
        checks++;
        step(1, 1, 0, 0);
        if (screenSel !== 2'd0 || livesLeft !== 2'(LIVES) || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL back_to_idle: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
    endtask

    task automatic test_levels();
        start_game();
        step(0, 0, 0, 1);
        if (screenSel !== 2'd2 || level !== 2'd2 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL level_up: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
        for (int i = 0; i < LEVELUP; i++) step(1, 0, 0, 0);
        if (screenSel !== 2'd1 || gameActive !== 1'b0 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL levelup_to_serve: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
        serve_out();
        step(0, 0, 0, 1);
        if (screenSel !== 2'd3 || gameWon !== 1'b1 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL game_won: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
        for (int i = 0; i < GAMEOVER; i++) step(1, 0, 0, 0);
        if (gameWon !== 1'b0 || level !== 2'd1 || screenSel !== 2'd0) begin
            errors++; $display("FAIL won_cleared: won=%0b level=%0d sel=%0d exp 0 1 0", gameWon, level, screenSel);
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        start_game();
        step(0, 0, 1, 0);
        serve_out();
        step(0, 0, 1, 0);
        serve_out();
        step(0, 0, 1, 1);
        if (screenSel !== 2'd2 || livesLeft !== 2'd1 || level !== 2'd2 || dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL simultaneous: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < LEVELUP; i++) step(1, 0, 0, 0);
        serve_out();
        if (gameActive !== 1'b1 || level !== 2'd2) begin
            errors++; $display("FAIL pre_reset_play: active=%0b level=%0d exp 1 2", gameActive, level);
        end
        checks++;
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        if ({screenSel, start, gameActive, ballRespawn, gameWon, livesLeft, level} !==
            {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1}) begin
            errors++; $display("FAIL async_reset: got %h exp %h", dut_bus(), {2'd0, 4'b0000, 2'd3, 2'd1});
        end
        checks++;
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        key0IsPressed = 1'b0;
        step(0, 0, 0, 0);
        if (dut_bus() !== exp_bus()) begin
            errors++; $display("FAIL after_reset: got %h exp %h", dut_bus(), exp_bus());
        end
        checks++;
    endtask

    task automatic test_random();
        bit s, k, l, c;
        int bad;
        bad = 0;
        k = 0;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) k = !k;
            l = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 11) == 0);
            step(s, k, l, c);
            if (dut_bus() !== exp_bus()) begin
                errors++;
                if (bad < 10) $display("FAIL random_cycle_%0d: got %h exp %h", i, dut_bus(), exp_bus());
                bad++;
            end
            checks++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_serve_timing();
        test_lives();
        test_levels();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
